// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative HI/LO multiply/divide unit, one bit per cycle.
// Build option MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module execute_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_in,
  output logic             ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  // IDLE accept | RUN iterate WIDTH cycles | FIX sign-correct + write | DONE pulse
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [W2-1:0]     p;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH-1:0]  a_r;
  logic [3:0]        op_r;
  logic              neg_a, neg_b;

  logic              multi_op, accept, start, mt_wr;
  logic              sgn_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]  a_mag_in, b_mag_in;
  logic              is_div_r;
  logic [WIDTH:0]    mul_sum, div_shift, div_diff;
  logic [W2-1:0]     step_nxt;
  logic [WIDTH-1:0]  q_mag, r_mag, quo, rem;
  logic [W2-1:0]     prod_fix, res;

  always_comb begin
    multi_op = (op <= OP_DIVU);
`ifdef MULDIV_MADD_EN
    if (op >= OP_MADD && op <= OP_MSUBU) multi_op = 1'b1;
`endif
  end

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign accept = valid_in && ready && !flush;
  assign start  = accept && multi_op;
  assign mt_wr  = accept && (op == OP_MTHI || op == OP_MTLO);

  // Signed ops are exactly the even opcodes among the multi-cycle ones
  assign sgn_in   = ~op[0];
  assign a_neg_in = sgn_in & a[WIDTH-1];
  assign b_neg_in = sgn_in & b[WIDTH-1];
  assign a_mag_in = a_neg_in ? -a : a;
  assign b_mag_in = b_neg_in ? -b : b;

  assign is_div_r = (op_r == OP_DIV) || (op_r == OP_DIVU);

  always_comb begin
    mul_sum   = {1'b0, p[W2-1:WIDTH]} + (p[0] ? {1'b0, b_mag} : '0);
    div_shift = p[W2-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_mag};
    if (is_div_r) begin
      if (!div_diff[WIDTH]) step_nxt = {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      else                  step_nxt = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end else begin
      step_nxt = {mul_sum, p[WIDTH-1:1]};
    end
  end

  always_comb begin
    q_mag    = p[WIDTH-1:0];
    r_mag    = p[W2-1:WIDTH];
    prod_fix = (neg_a ^ neg_b) ? -p : p;
    quo      = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem      = neg_a ? -r_mag : r_mag;
    if (is_div_r) begin
      if (b_mag == '0) res = {a_r, {WIDTH{1'b1}}};
      else             res = {rem, quo};
    end else begin
      res = prod_fix;
`ifdef MULDIV_MADD_EN
      if (op_r == OP_MADD || op_r == OP_MADDU)      res = {hi, lo} + prod_fix;
      else if (op_r == OP_MSUB || op_r == OP_MSUBU) res = {hi, lo} - prod_fix;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      p     <= '0;
      b_mag <= '0;
      a_r   <= '0;
      op_r  <= OP_MULT;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (start) begin
        cnt   <= CW'(WIDTH - 1);
        p     <= {{WIDTH{1'b0}}, a_mag_in};
        b_mag <= b_mag_in;
        a_r   <= a;
        op_r  <= op;
        neg_a <= a_neg_in;
        neg_b <= b_neg_in;
      end else if (state == RUN) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        p <= step_nxt;
      end
      if (mt_wr) begin
        if (op == OP_MTHI) hi <= a;
        else               lo <= a;
      end
      if (state == FIX && !flush) begin
        hi <= res[W2-1:WIDTH];
        lo <= res[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv (WIDTH=32): expected HI/LO queued at issue, popped on done.
module tb_execute_muldiv;
  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         valid_in = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done;
  logic [W-1:0] hi, lo;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [63:0]  sb_q[$];
  logic [63:0]  mon_exp;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  execute_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .valid_in(valid_in), .ready(ready), .op(op),
    .a(a), .b(b), .flush(flush), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic [63:0] acc);
    longint      sx, sy;
    logic [63:0] ux, uy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = acc;
    case (o)
      4'd0: r = 64'(sx * sy);
      4'd1: r = ux * uy;
      4'd2: if (y == '0) r = {x, 32'hFFFF_FFFF};
            else         r = {32'(sx % sy), 32'(sx / sy)};
      4'd3: if (y == '0) r = {x, 32'hFFFF_FFFF};
            else         r = {32'(ux % uy), 32'(ux / uy)};
      4'd6: r = acc + 64'(sx * sy);
      4'd7: r = acc + ux * uy;
      4'd8: r = acc - 64'(sx * sy);
      4'd9: r = acc - ux * uy;
      default: r = acc;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("hilo", {hi, lo}, mon_exp);
      end
    end
  end

  task automatic drive(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    valid_in = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic do_multi(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    int lat, rdy_hi;
    e = model(o, x, y, {m_hi, m_lo});
    sb_q.push_back(e);
    {m_hi, m_lo} = e;
    drive(o, x, y);
    lat = 0;
    rdy_hi = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (ready) rdy_hi++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(LAT));
    chk("ready_busy", 64'(rdy_hi), 64'd0);
    @(negedge clk);
    chk("ready_after", {63'd0, ready}, 64'd1);
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_multi(4'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_multi(4'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_multi(4'd3, 32'd5, 32'd0);
    chk("divu_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    do_multi(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_multi(4'd2, 32'hFFFF_FFF0, 32'd0);
    do_multi(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 16; i++) begin
      logic [3:0]   o;
      logic [W-1:0] x, y;
      o = 4'($urandom_range(0, 3));
`ifdef MULDIV_MADD_EN
      if ($urandom_range(0, 2) == 0) o = 4'(6 + $urandom_range(0, 3));
`endif
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = '0;
        1: y = W'($urandom_range(1, 15));
        2: y = -W'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      do_multi(o, x, y);
    end

    // MTHI/MTLO back to back, then accumulate
    valid_in = 1'b1;
    op = 4'd4;
    a = 32'd0;
    @(posedge clk);
    #1;
    chk("mthi_ready", {63'd0, ready}, 64'd1);
    chk("mthi_hi", 64'(hi), 64'd0);
    op = 4'd5;
    a = 32'd1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd1;
    chk("mtlo_pair", {hi, lo}, 64'h0000_0000_0000_0001);
    chk("mtlo_ready", {63'd0, ready}, 64'd1);
`ifdef MULDIV_MADD_EN
    do_multi(4'd6, 32'd2, 32'd3);
    chk("madd", {hi, lo}, 64'd7);
`else
    drive(4'd6, 32'd2, 32'd3);
    chk("madd_off_ready", {63'd0, ready}, 64'd1);
    idle_wait(LAT + 6);
    chk("madd_off", {hi, lo}, 64'd1);
`endif

    drive(4'd12, 32'hDEAD_BEEF, 32'd1);
    chk("illegal_ready", {63'd0, ready}, 64'd1);
    idle_wait(LAT + 4);
    chk("illegal_hilo", {hi, lo}, {m_hi, m_lo});

    // Flush mid-run keeps HI/LO
    drive(4'd4, 32'h11, 32'd0);
    drive(4'd5, 32'h22, 32'd0);
    m_hi = 32'h11;
    m_lo = 32'h22;
    drive(4'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    chk("flush_busy", {63'd0, ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_ready", {63'd0, ready}, 64'd1);
    chk("flush_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    idle_wait(LAT + 6);
    chk("flush_hilo_late", {hi, lo}, 64'h0000_0011_0000_0022);

    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    drive(4'd4, 32'h99, 32'd0);
    chk("flush_idle_mt", 64'(hi), 64'h11);
    drive(4'd0, 32'd3, 32'd3);
    flush = 1'b0;
    chk("flush_idle_start", {63'd0, ready}, 64'd1);
    idle_wait(LAT + 4);

    // Asynchronous reset mid-run
    drive(4'd0, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_ready", {63'd0, ready}, 64'd1);
    chk("arst_done", {63'd0, done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    do_multi(4'd0, 32'h7FFF_FFFF, 32'h8000_0000);
    do_multi(4'd3, 32'hFFFF_FFFF, 32'd10);

    idle_wait(4);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  operation request.
REQ-005 SHALL have port ready  output  1  unit can accept; a request is accepted on a clk edge where valid_in && ready.
REQ-006 SHALL have port op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 illegal.
REQ-007 SHALL have ports a, b  input  WIDTH  operands (rs, rt); sampled only at accept.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have port done  output  1  one-cycle pulse: HI/LO hold the new result.
REQ-010 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers, always driven.

Function
REQ-011 SHALL use FSM IDLE -> RUN -> FIX -> DONE -> IDLE; ready=1 only in IDLE; done=1 only in DONE.
REQ-012 SHALL, on accepting ops 0-3 and 6-9, latch operands, enter RUN, and iterate 1 bit/cycle for exactly WIDTH cycles (shift-add multiply, restoring divide on magnitudes).
REQ-013 SHALL, in FIX (1 cycle), apply sign correction and write HI/LO at its end; done pulses in the following cycle; accept-to-done latency = WIDTH+2 cycles.
REQ-014 SHALL produce MULT/MULTU {HI,LO} = 2*WIDTH-bit signed/unsigned product.
REQ-015 SHALL produce DIV/DIVU LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-016 SHALL, on b=0 (DIV or DIVU), yield LO=all ones, HI=a; no exception, same latency.
REQ-017 SHALL, on DIV of most-negative by -1, yield LO=most-negative, HI=0.
REQ-018 SHALL, on accepting MTHI/MTLO, write a to HI/LO at that edge, stay IDLE, ready stays 1, no done.
REQ-019 SHALL, on accepting an illegal op, discard it: no state change, no done.
REQ-020 SHALL, on flush=1, go to IDLE next edge from any state; HI/LO unchanged; no done; flush in IDLE with valid_in blocks acceptance that cycle.
REQ-021 SHALL keep hi/lo stable except at REQ-013/018 writes.

Reset
REQ-022 SHALL, on resetn=0, immediately force state IDLE, hi=0, lo=0, done=0, ready=1, internal counters/accumulators 0; in-flight operation discarded.
REQ-023 SHALL resume accepting on the first edge after resetn deasserts.

Configuration
REQ-024 SHALL, with MULDIV_MADD_EN defined, execute MADD/MADDU/MSUB/MSUBU: {HI,LO} at FIX plus/minus signed/unsigned product, modulo 2^(2*WIDTH), same latency as MULT.
REQ-025 SHALL, without MULDIV_MADD_EN, treat ops 6-9 as illegal per REQ-019, with no accumulate logic built.

Verification (WIDTH=32)
REQ-026 SHALL cover MULT a=0xFFFFFFFD b=7 accepted at cycle 0 -> done at cycle 34, HI=0xFFFFFFFF LO=0xFFFFFFEB; ready=0 cycles 1-34.
REQ-027 SHALL cover DIV a=0xFFFFFFF9 b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU a=5 b=0 -> LO=0xFFFFFFFF HI=5.
REQ-028 SHALL cover DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-029 SHALL cover HI=0x11 LO=0x22, DIVU started, flush at cycle 10 -> no done, HI=0x11 LO=0x22, ready=1 at cycle 11; resetn pulse mid-RUN -> HI=LO=0, ready=1 immediately.
REQ-030 SHALL cover MTHI a=0 and MTLO a=1 back-to-back, then MADD a=2 b=3 -> with MULDIV_MADD_EN, HI=0 LO=7 after done; without, no done and HI=0 LO=1.
